// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, taken-branch flush and data-memory freeze,
// with saturating stall/flush counters and a sticky memory-wait timeout flag.
module hazard_ctrl #(
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             MemRead_ex,
   input  logic [4:0]       rdAddr_ex,
   input  logic [4:0]       rs1Addr_id,
   input  logic [4:0]       rs2Addr_id,
   input  logic             rs1Used_id,
   input  logic             rs2Used_id,
   input  logic             BranchTaken_ex,
   input  logic             dmem_req_mem,
   input  logic             dmem_ready,
   input  logic             cnt_clr,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEXWrite,
   output logic             EXMEMWrite,
   output logic             IFIDFlush,
   output logic             IDEXFlush,
   output logic             MEMWBFlush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WAIT_W = $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;
   logic [CNT_W-1:0]   flushCnt_q, flushCnt_d;

   logic memHold;
   logic loadUse;
   logic branchActed;

   assign memHold = dmem_req_mem && !dmem_ready;
   assign loadUse = MemRead_ex && (rdAddr_ex != 5'd0) &&
                    ((rs1Used_id && (rs1Addr_id == rdAddr_ex)) ||
                     (rs2Used_id && (rs2Addr_id == rdAddr_ex)));
   assign branchActed = rst_n && BranchTaken_ex && !memHold;

   // While reset is held the outputs stay at the free-running defaults.
   always_comb begin
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IDEXWrite  = 1'b1;
      EXMEMWrite = 1'b1;
      IFIDFlush  = 1'b0;
      IDEXFlush  = 1'b0;
      MEMWBFlush = 1'b0;
      state_d    = RUN;
      if (rst_n) begin
         if (memHold) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            MEMWBFlush = 1'b1;
            state_d    = MEM_WAIT;
         end else if (BranchTaken_ex) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
         end else if (loadUse && (state_q != LOAD_STALL)) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
            state_d   = LOAD_STALL;
         end
      end
   end

   // The entry cycle counts as the first hold cycle, so TIMEOUT hold cycles raise the flag.
   always_comb begin
      waitCnt_d = '0;
      timeout_d = timeout_q;
      if (memHold) begin
         if (state_q != MEM_WAIT) begin
            waitCnt_d = WAIT_W'(1);
         end else if (waitCnt_q == WAIT_LAST) begin
            waitCnt_d = waitCnt_q;
            timeout_d = 1'b1;
         end else begin
            waitCnt_d = waitCnt_q + WAIT_W'(1);
         end
      end
   end

   always_comb begin
      stallCnt_d = stallCnt_q;
      flushCnt_d = flushCnt_q;
      if (cnt_clr) begin
         stallCnt_d = '0;
         flushCnt_d = '0;
      end else begin
         if (!PCWrite && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + CNT_W'(1);
         if (branchActed && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         waitCnt_q  <= '0;
         timeout_q  <= 1'b0;
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         waitCnt_q  <= waitCnt_d;
         timeout_q  <= timeout_d;
         stallCnt_q <= stallCnt_d;
         flushCnt_q <= flushCnt_d;
      end
   end

   assign mem_timeout = timeout_q;
   assign stall_cnt   = stallCnt_q;
   assign flush_cnt   = flushCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: expected control vectors are queued when stimulus
// is driven and popped when the combinational outputs are sampled mid-cycle.
module tb_hazard_ctrl;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 2;

   // {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBFlush}
   localparam logic [6:0] NORM   = 7'b1111_000;
   localparam logic [6:0] LSTALL = 7'b0011_010;
   localparam logic [6:0] BRANCH = 7'b1111_110;
   localparam logic [6:0] FREEZE = 7'b0000_001;

   typedef struct packed {
      logic       memRead;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic       rs1u;
      logic [4:0] rs2;
      logic       rs2u;
      logic       br;
      logic       req;
      logic       rdy;
      logic       clr;
   } stim_t;

   logic             clk;
   logic             rst_n;
   logic             MemRead_ex;
   logic [4:0]       rdAddr_ex;
   logic [4:0]       rs1Addr_id;
   logic [4:0]       rs2Addr_id;
   logic             rs1Used_id;
   logic             rs2Used_id;
   logic             BranchTaken_ex;
   logic             dmem_req_mem;
   logic             dmem_ready;
   logic             cnt_clr;
   logic             PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
   logic             IFIDFlush, IDEXFlush, MEMWBFlush;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [6:0]       ctrl;

   int checks   = 0;
   int failures = 0;
   logic [6:0] expQ[$];

   assign ctrl = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBFlush};

   hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
      .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
      .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
      .BranchTaken_ex(BranchTaken_ex), .dmem_req_mem(dmem_req_mem),
      .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
      .EXMEMWrite(EXMEMWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
      .MEMWBFlush(MEMWBFlush), .mem_timeout(mem_timeout),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic stim_t st(input logic memRead, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic rs1u,
                                input logic [4:0] rs2, input logic rs2u,
                                input logic br, input logic req, input logic rdy,
                                input logic clr);
      stim_t s;
      s.memRead = memRead; s.rd = rd; s.rs1 = rs1; s.rs1u = rs1u;
      s.rs2 = rs2; s.rs2u = rs2u; s.br = br; s.req = req; s.rdy = rdy; s.clr = clr;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      MemRead_ex     = s.memRead;
      rdAddr_ex      = s.rd;
      rs1Addr_id     = s.rs1;
      rs1Used_id     = s.rs1u;
      rs2Addr_id     = s.rs2;
      rs2Used_id     = s.rs2u;
      BranchTaken_ex = s.br;
      dmem_req_mem   = s.req;
      dmem_ready     = s.rdy;
      cnt_clr        = s.clr;
   endtask

   // Drives one cycle of stimulus at the falling edge and queues its expected control vector.
   task automatic applyStimulus(input stim_t s, input logic [6:0] exp);
      @(negedge clk);
      drive(s);
      expQ.push_back(exp);
   endtask

   task automatic clearCounters();
      @(negedge clk);
      drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] exp;
      rst_n = 1'b0;
      drive(st(1, 5, 5, 1, 0, 0, 1, 1, 0, 0));
      expQ.push_back(NORM);
      #2;
      exp = expQ.pop_front();
      checks++;
      if (ctrl !== exp) begin failures++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, exp); end
      checks++;
      if (stall_cnt !== 2'd0) begin failures++; $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
      checks++;
      if (flush_cnt !== 2'd0) begin failures++; $display("[TB] FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
      checks++;
      if (mem_timeout !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout: got %b expected 0", mem_timeout); end
      @(negedge clk);
      drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      stim_t      s[3];
      logic [6:0] e[3];
      logic [6:0] exp;
      s[0] = st(1, 5, 5, 1, 0, 0, 0, 0, 1, 0); e[0] = LSTALL;
      s[1] = st(1, 5, 5, 1, 0, 0, 0, 0, 1, 0); e[1] = NORM;
      s[2] = st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[2] = NORM;
      clearCounters();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(s[i], e[i]);
         #2;
         exp = expQ.pop_front();
         checks++;
         if (ctrl !== exp) begin failures++; $display("[TB] FAIL load_use step %0d: got %b expected %b", i, ctrl, exp); end
         @(posedge clk);
         #1;
      end
      checks++;
      if (stall_cnt !== 2'd1) begin failures++; $display("[TB] FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt); end
   endtask

   task automatic test_no_stall();
      stim_t      s[4];
      logic [6:0] e[4];
      logic [6:0] exp;
      s[0] = st(1, 0, 0, 1, 0, 1, 0, 0, 1, 0); e[0] = NORM;
      s[1] = st(1, 5, 3, 1, 5, 0, 0, 0, 1, 0); e[1] = NORM;
      s[2] = st(1, 7, 3, 1, 7, 1, 0, 0, 1, 0); e[2] = LSTALL;
      s[3] = st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[3] = NORM;
      clearCounters();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(s[i], e[i]);
         #2;
         exp = expQ.pop_front();
         checks++;
         if (ctrl !== exp) begin failures++; $display("[TB] FAIL no_stall step %0d: got %b expected %b", i, ctrl, exp); end
         @(posedge clk);
         #1;
         if (i == 1) begin
            checks++;
            if (stall_cnt !== 2'd0) begin failures++; $display("[TB] FAIL no_stall_cnt: got %0d expected 0", stall_cnt); end
         end
      end
   endtask

   task automatic test_branch_priority();
      stim_t      s[3];
      logic [6:0] e[3];
      logic [6:0] exp;
      s[0] = st(1, 5, 5, 1, 0, 0, 1, 0, 1, 0); e[0] = BRANCH;
      s[1] = st(0, 0, 0, 0, 0, 0, 1, 0, 1, 0); e[1] = BRANCH;
      s[2] = st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[2] = NORM;
      clearCounters();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(s[i], e[i]);
         #2;
         exp = expQ.pop_front();
         checks++;
         if (ctrl !== exp) begin failures++; $display("[TB] FAIL branch step %0d: got %b expected %b", i, ctrl, exp); end
         @(posedge clk);
         #1;
         if (i == 0) begin
            checks++;
            if (flush_cnt !== 2'd1) begin failures++; $display("[TB] FAIL branch_flush_cnt1: got %0d expected 1", flush_cnt); end
         end
      end
      checks++;
      if (flush_cnt !== 2'd2) begin failures++; $display("[TB] FAIL branch_flush_cnt2: got %0d expected 2", flush_cnt); end
      checks++;
      if (stall_cnt !== 2'd0) begin failures++; $display("[TB] FAIL branch_stall_cnt: got %0d expected 0", stall_cnt); end
   endtask

   task automatic test_mem_freeze();
      stim_t      s[5];
      logic [6:0] e[5];
      logic [6:0] exp;
      for (int i = 0; i < 3; i++) begin
         s[i] = st(1, 5, 5, 1, 0, 0, 1, 1, 0, 0); e[i] = FREEZE;
      end
      s[3] = st(0, 0, 0, 0, 0, 0, 1, 1, 1, 0); e[3] = BRANCH;
      s[4] = st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[4] = NORM;
      clearCounters();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(s[i], e[i]);
         #2;
         exp = expQ.pop_front();
         checks++;
         if (ctrl !== exp) begin failures++; $display("[TB] FAIL mem_freeze step %0d: got %b expected %b", i, ctrl, exp); end
         @(posedge clk);
         #1;
      end
      checks++;
      if (stall_cnt !== 2'd3) begin failures++; $display("[TB] FAIL freeze_stall_cnt: got %0d expected 3", stall_cnt); end
      checks++;
      if (flush_cnt !== 2'd1) begin failures++; $display("[TB] FAIL freeze_flush_cnt: got %0d expected 1", flush_cnt); end
      checks++;
      if (mem_timeout !== 1'b0) begin failures++; $display("[TB] FAIL freeze_timeout: got %b expected 0", mem_timeout); end
   endtask

   task automatic test_timeout();
      logic [6:0] exp;
      logic       expTo;
      for (int i = 0; i < 7; i++) begin
         if (i < 6) applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), FREEZE);
         else       applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), NORM);
         #2;
         exp = expQ.pop_front();
         checks++;
         if (ctrl !== exp) begin failures++; $display("[TB] FAIL timeout_ctrl step %0d: got %b expected %b", i, ctrl, exp); end
         @(posedge clk);
         #1;
         expTo = (i >= 3);
         checks++;
         if (mem_timeout !== expTo) begin failures++; $display("[TB] FAIL timeout_flag edge %0d: got %b expected %b", i + 1, mem_timeout, expTo); end
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), FREEZE);
         #2;
         exp = expQ.pop_front();
         checks++;
         if (ctrl !== exp) begin failures++; $display("[TB] FAIL timeout_rehold step %0d: got %b expected %b", i, ctrl, exp); end
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      expQ.push_back(NORM);
      #1;
      exp = expQ.pop_front();
      checks++;
      if (ctrl !== exp) begin failures++; $display("[TB] FAIL async_reset_ctrl: got %b expected %b", ctrl, exp); end
      checks++;
      if (mem_timeout !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_timeout: got %b expected 0", mem_timeout); end
      checks++;
      if (stall_cnt !== 2'd0) begin failures++; $display("[TB] FAIL async_reset_stall_cnt: got %0d expected 0", stall_cnt); end
      @(negedge clk);
      drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      rst_n = 1'b1;
   endtask

   task automatic test_saturation();
      logic [6:0]       exp;
      logic [CNT_W-1:0] expCnt;
      clearCounters();
      for (int i = 0; i < 7; i++) begin
         if (i < 5)       applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), FREEZE);
         else if (i == 5) applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), FREEZE);
         else             applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), NORM);
         #2;
         exp = expQ.pop_front();
         checks++;
         if (ctrl !== exp) begin failures++; $display("[TB] FAIL sat_ctrl step %0d: got %b expected %b", i, ctrl, exp); end
         @(posedge clk);
         #1;
         expCnt = (i >= 5) ? 2'd0 : ((i >= 2) ? 2'd3 : CNT_W'(i + 1));
         checks++;
         if (stall_cnt !== expCnt) begin failures++; $display("[TB] FAIL sat_stall_cnt step %0d: got %0d expected %0d", i, stall_cnt, expCnt); end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch_priority();
      test_mem_freeze();
      test_timeout();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
